mem_port_arbiter: RTL

//  Shares one SRAM-like memory port between the fetch stage (instruction read) and the

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and data access,
// one outstanding transaction at a time, and generates the pipeline stalls.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            i_stall,
    output logic            d_stall,
    output logic            longest_stall,
    output logic            m_req,
    output logic            m_wr,
    output logic [DW/8-1:0] m_wstrb,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata
);

    typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT} arbState_e;

    arbState_e state, stateNext;
    logic      instDone, dataDone;
    logic      startI, startD, accept, finishI, finishD;

    assign i_stall       = inst_req & ~instDone;
    assign d_stall       = data_req & ~dataDone;
    assign longest_stall = i_stall | d_stall;

    // NOTE: async reset only covers flops; every register here is a plain flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        stateNext = state;
        startI    = 1'b0;
        startD    = 1'b0;
        accept    = 1'b0;
        finishI   = 1'b0;
        finishD   = 1'b0;
        case (state)
            IDLE: begin
                if (d_stall && (DATA_FIRST || !i_stall)) begin
                    startD    = 1'b1;
                    stateNext = D_ADDR;
                end else if (i_stall) begin
                    startI    = 1'b1;
                    stateNext = I_ADDR;
                end
            end
            D_ADDR: begin
                if (m_addr_ok) begin
                    accept = 1'b1;
                    if (m_data_ok) begin
                        finishD   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (m_data_ok) begin
                    finishD   = 1'b1;
                    stateNext = IDLE;
                end
            end
            I_ADDR: begin
                if (m_addr_ok) begin
                    accept = 1'b1;
                    if (m_data_ok) begin
                        finishI   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = I_WAIT;
                    end
                end
            end
            I_WAIT: begin
                if (m_data_ok) begin
                    finishI   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Bus fields stay loaded after acceptance; m_wr still identifies a store at completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req      <= 1'b0;
            m_wr       <= 1'b0;
            m_wstrb    <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            instDone   <= 1'b0;
            dataDone   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (startD) begin
                m_req   <= 1'b1;
                m_wr    <= data_wr;
                m_wstrb <= data_wr ? data_wstrb : '0;
                m_addr  <= data_addr;
                m_wdata <= data_wdata;
            end else if (startI) begin
                m_req   <= 1'b1;
                m_wr    <= 1'b0;
                m_wstrb <= '0;
                m_addr  <= inst_addr;
                m_wdata <= '0;
            end else if (accept) begin
                m_req <= 1'b0;
            end

            if (finishI)          inst_rdata <= m_rdata;
            if (finishD && !m_wr) data_rdata <= m_rdata;

            // A flag survives until the pipeline advances, unless set again this cycle.
            instDone <= finishI | (instDone & longest_stall);
            dataDone <= finishD | (dataDone & longest_stall);
        end
    end

endmodule
